level_select_n: RTL and testbench

//  Parametrised keypad difficulty selector for NUM_LEVELS levels plus a restart key.

---
 rtl/level_select_pkg.sv | 34 +++
 rtl/level_select_n_key_debounce.sv | 67 ++++++
 rtl/level_select_n.sv | 157 +++++++++++++++
 tb/tb_level_select_n.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/level_select_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | level_select_pkg                                                        |
// | Shared state type, default constants and helper for level_select_n.    |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
package level_select_pkg;

   typedef enum logic [1:0] {
      S_RESTART = 2'd0,
      S_SELECT  = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   localparam int DEF_NUM_LEVELS       = 3;
   localparam int DEF_LEVEL_W          = 3;
   localparam int DEF_SYNC_STAGES      = 2;
   localparam int DEF_DEBOUNCE_CYCLES  = 4;
   localparam int DEF_RST_PULSE_CYCLES = 2;

   // Highest set bit wins; callers only pass true one-hot vectors (max 8 keys)
   function automatic logic [3:0] onehot_to_code(input logic [7:0] onehot);
      logic [3:0] code;
      code = '0;
      for (int i = 0; i < 8; i++) begin
         if (onehot[i]) begin
            code = 4'(i + 1);
         end
      end
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/level_select_n_key_debounce.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | key_debounce                                                            |
// | Synchroniser + stability-counter debouncer with registered press pulse. |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module key_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic key_level,
   output logic key_press
);

   // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_level_q;
   logic                   r_press;

   // Metastability chain for the asynchronous key
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw};
      end
   end

   // Flip the debounced level after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (r_sync[SYNC_STAGES-1] == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt   <= '0;
         r_level <= ~r_level;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Registered rising-edge detect on the debounced level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level_q <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_level_q <= r_level;
         r_press   <= r_level & ~r_level_q;
      end
   end

   assign key_level = r_level;
   assign key_press = r_press;

endmodule
`default_nettype wire

// File: rtl/level_select_n.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | level_select_n                                                          |
// | Keypad difficulty selector: debounced level keys, one-shot latch with   |
// | lockout, restart key and fixed-length game_rst pulse.                   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module level_select_n
   import level_select_pkg::*;
#(
   parameter int NUM_LEVELS       = DEF_NUM_LEVELS,
   parameter int LEVEL_W          = DEF_LEVEL_W,
   parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
   parameter int RST_PULSE_CYCLES = DEF_RST_PULSE_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_LEVELS-1:0] key_level,
   input  logic                  key_restart,
   output logic [NUM_LEVELS-1:0] level_onehot,
   output logic [LEVEL_W-1:0]    level_code,
   output logic                  level_valid,
   output logic                  game_rst,
   output logic                  sel_error
);

   localparam int PCNT_W = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RST_PULSE_CYCLES - 1);

   // Elaboration-time parameter sanity
   if ((2 ** LEVEL_W) <= NUM_LEVELS) begin : g_bad_level_w
      $error("level_select_n: LEVEL_W too narrow for NUM_LEVELS");
   end
   if ((NUM_LEVELS < 1) || (NUM_LEVELS > 8)) begin : g_bad_num_levels
      $error("level_select_n: NUM_LEVELS must be 1..8");
   end

   logic [NUM_LEVELS-1:0] lvl_deb;
   logic [NUM_LEVELS-1:0] lvl_press;
   logic                  restart_level_unused;
   logic                  restart_press;

   for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_level_key
      key_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_key (
         .clk       (clk),
         .rst       (rst),
         .key_raw   (key_level[i]),
         .key_level (lvl_deb[i]),
         .key_press (lvl_press[i])
      );
   end

   key_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_restart_key (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_restart),
      .key_level (restart_level_unused),
      .key_press (restart_press)
   );

   logic [3:0] press_cnt;
   logic       other_held;

   // Number of level presses this cycle and whether a non-pressing key is held
   always_comb begin
      press_cnt = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         press_cnt = press_cnt + {3'b000, lvl_press[i]};
      end
      other_held = |(lvl_deb & ~lvl_press);
   end

   state_t                r_state,  state_nxt;
   logic [PCNT_W-1:0]     r_pcnt,   pcnt_nxt;
   logic [NUM_LEVELS-1:0] r_onehot, onehot_nxt;
   logic [LEVEL_W-1:0]    r_code,   code_nxt;
   logic                  r_valid,  valid_nxt;
   logic                  r_err,    err_nxt;

   // State, pulse counter and selection registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_RESTART;
         r_pcnt   <= '0;
         r_onehot <= '0;
         r_code   <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= state_nxt;
         r_pcnt   <= pcnt_nxt;
         r_onehot <= onehot_nxt;
         r_code   <= code_nxt;
         r_valid  <= valid_nxt;
         r_err    <= err_nxt;
      end
   end

   // Next-state: restart press dominates, then per-state selection rules
   always_comb begin
      state_nxt  = r_state;
      pcnt_nxt   = r_pcnt;
      onehot_nxt = r_onehot;
      code_nxt   = r_code;
      valid_nxt  = r_valid;
      err_nxt    = 1'b0;
      if (restart_press) begin
         state_nxt  = S_RESTART;
         pcnt_nxt   = '0;
         onehot_nxt = '0;
         code_nxt   = '0;
         valid_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_RESTART: begin
               if (r_pcnt == PCNT_LAST) begin
                  state_nxt = S_SELECT;
               end else begin
                  pcnt_nxt = r_pcnt + 1'b1;
               end
            end
            S_SELECT: begin
               if ((press_cnt == 4'd1) && !other_held) begin
                  onehot_nxt = lvl_press;
                  code_nxt   = LEVEL_W'(onehot_to_code(8'(lvl_press)));
                  valid_nxt  = 1'b1;
                  state_nxt  = S_LOCKED;
               end else if (press_cnt != 4'd0) begin
                  err_nxt = 1'b1;
               end
            end
            S_LOCKED: begin
               state_nxt = S_LOCKED;
            end
            default: begin
               state_nxt = S_RESTART;
               pcnt_nxt  = '0;
            end
         endcase
      end
   end

   assign level_onehot = r_onehot;
   assign level_code   = r_code;
   assign level_valid  = r_valid;
   assign sel_error    = r_err;
   assign game_rst     = (r_state == S_RESTART);

endmodule
`default_nettype wire

// File: tb/tb_level_select_n.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_level_select_n                                                       |
// | Self-checking bench: window-based behavioural model + directed cases.   |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_level_select_n;

   localparam int N  = 3;
   localparam int LW = 3;
   localparam int S  = 2;
   localparam int D  = 4;
   localparam int P  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  key_level = '0;
   logic          key_restart = 1'b0;
   logic [N-1:0]  level_onehot;
   logic [LW-1:0] level_code;
   logic          level_valid;
   logic          game_rst;
   logic          sel_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   level_select_n #(
      .NUM_LEVELS       (N),
      .LEVEL_W          (LW),
      .SYNC_STAGES      (S),
      .DEBOUNCE_CYCLES  (D),
      .RST_PULSE_CYCLES (P)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_level    (key_level),
      .key_restart  (key_restart),
      .level_onehot (level_onehot),
      .level_code   (level_code),
      .level_valid  (level_valid),
      .game_rst     (game_rst),
      .sel_error    (sel_error)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- behavioural model ----------------
   // Each key: raw samples per edge kept in a queue; the debouncer sees the
   // raw value from S edges back and flips when the last D of those all
   // differ from the current debounced level. Key index N is restart.
   bit hist [0:N][$];
   bit m_deb [0:N];
   bit m_deb_prev [0:N];
   bit m_press [0:N];
   int m_mode;      // 0 restart pulse, 1 selecting, 2 locked
   int m_left;      // remaining game_rst cycles
   int m_sel;       // 0 none, else level index+1
   bit m_err;
   bit m_ready = 1'b0;

   always @(posedge clk) begin : model
      bit raw [0:N];
      int npress;
      bit others;
      bit all_diff;
      for (int k = 0; k <= N; k++) raw[k] = (k < N) ? key_level[k] : key_restart;
      if (rst) begin
         for (int k = 0; k <= N; k++) begin
            hist[k].delete();
            for (int j = 0; j < S + D; j++) hist[k].push_back(1'b0);
            m_deb[k] = 0; m_deb_prev[k] = 0; m_press[k] = 0;
         end
         m_mode = 0; m_left = P; m_sel = 0; m_err = 0; m_ready = 1'b1;
      end else begin
         npress = 0; others = 0;
         for (int k = 0; k < N; k++) begin
            npress += int'(m_press[k]);
            if (m_deb[k] && !m_press[k]) others = 1;
         end
         m_err = 0;
         if (m_press[N]) begin
            m_mode = 0; m_left = P; m_sel = 0;
         end else if (m_mode == 0) begin
            m_left--;
            if (m_left == 0) m_mode = 1;
         end else if (m_mode == 1) begin
            if (npress == 1 && !others) begin
               for (int k = 0; k < N; k++) if (m_press[k]) m_sel = k + 1;
               m_mode = 2;
            end else if (npress > 0) begin
               m_err = 1;
            end
         end
         for (int k = 0; k <= N; k++) begin
            hist[k].push_back(raw[k]);
            void'(hist[k].pop_front());
            all_diff = 1;
            for (int j = 0; j < D; j++) if (hist[k][j] == m_deb[k]) all_diff = 0;
            m_press[k]    = m_deb[k] && !m_deb_prev[k];
            m_deb_prev[k] = m_deb[k];
            if (all_diff) m_deb[k] = !m_deb[k];
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model
   always @(negedge clk) begin : compare
      logic [N-1:0] e_onehot;
      if (m_ready) begin
         e_onehot = '0;
         if (m_sel != 0) e_onehot[m_sel-1] = 1'b1;
         check("m_onehot", int'(level_onehot), int'(e_onehot));
         check("m_code",   int'(level_code),   m_sel);
         check("m_valid",  int'(level_valid),  int'(m_sel != 0));
         check("m_grst",   int'(game_rst),     int'(m_mode == 0));
         check("m_err",    int'(sel_error),    int'(m_err));
      end
   end

   task automatic do_restart();
      key_restart = 1'b1; cyc(8);
      key_restart = 1'b0; cyc(8);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int errs;
      int grst_n;
      int hold [0:N];
      bit v;
      logic [N-1:0] kv;

      // 1: reset release, game_rst high for exactly 2 clocks
      rst = 1'b1; cyc(3);
      rst = 1'b0;
      check("t1_grst_a", int'(game_rst), 1);
      check("t1_valid",  int'(level_valid), 0);
      cyc(1); check("t1_grst_b", int'(game_rst), 1);
      cyc(1); check("t1_grst_c", int'(game_rst), 0);

      // 2: hold key 1 -> valid rises 7 clocks after first raw-high sample
      key_level = 3'b010;
      cyc(7); check("t2_valid_early", int'(level_valid), 0);
      cyc(1);
      check("t2_valid",  int'(level_valid), 1);
      check("t2_code",   int'(level_code), 2);
      check("t2_onehot", int'(level_onehot), 2);
      key_level = 3'b110;
      errs = 0;
      for (int i = 0; i < 12; i++) begin cyc(1); errs += int'(sel_error); end
      check("t2_locked_err", errs, 0);
      check("t2_locked_code", int'(level_code), 2);
      key_level = '0; cyc(10);

      // 3: two keys together -> one error pulse, then key 2 alone
      do_restart();
      check("t3_cleared", int'(level_valid), 0);
      key_level = 3'b101;
      errs = 0;
      for (int i = 0; i < 12; i++) begin cyc(1); errs += int'(sel_error); end
      check("t3_err_pulses", errs, 1);
      check("t3_valid", int'(level_valid), 0);
      key_level = '0; cyc(10);
      key_level = 3'b100; cyc(10);
      check("t3_code", int'(level_code), 3);
      key_level = '0; cyc(10);

      // 4: 3-clock glitch is rejected
      do_restart();
      key_level = 3'b001; cyc(3);
      key_level = '0; cyc(12);
      check("t4_valid", int'(level_valid), 0);
      check("t4_code",  int'(level_code), 0);

      // 5: lock at 1, restart, re-select 3
      key_level = 3'b001; cyc(10);
      check("t5_code1", int'(level_code), 1);
      key_level = '0; cyc(6);
      key_restart = 1'b1;
      grst_n = 0;
      for (int i = 0; i < 14; i++) begin cyc(1); grst_n += int'(game_rst); end
      check("t5_grst_len", grst_n, 2);
      check("t5_valid", int'(level_valid), 0);
      check("t5_code0", int'(level_code), 0);
      key_restart = 1'b0; cyc(8);
      key_level = 3'b100; cyc(10);
      check("t5_code3", int'(level_code), 3);
      key_level = '0; cyc(10);

      // 6: restart and level together -> restart wins; rst mid pulse
      do_restart();
      key_restart = 1'b1; key_level = 3'b010; cyc(12);
      check("t6_code", int'(level_code), 0);
      check("t6_valid", int'(level_valid), 0);
      key_restart = 1'b0; key_level = '0; cyc(10);
      key_restart = 1'b1;
      for (int i = 0; i < 20 && !game_rst; i++) cyc(1);
      check("t6_grst_seen", int'(game_rst), 1);
      rst = 1'b1; cyc(1);
      check("t6_rst_onehot", int'(level_onehot), 0);
      check("t6_rst_code",   int'(level_code), 0);
      check("t6_rst_valid",  int'(level_valid), 0);
      check("t6_rst_err",    int'(sel_error), 0);
      check("t6_rst_grst",   int'(game_rst), 1);
      rst = 1'b0; key_restart = 1'b0;
      cyc(1); check("t6_grst_b", int'(game_rst), 1);
      cyc(1); check("t6_grst_c", int'(game_rst), 0);

      // Random phase: keys held for random spans, rare restart and rst
      for (int k = 0; k <= N; k++) hold[k] = 0;
      kv = '0;
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k <= N; k++) begin
            if (hold[k] == 0) begin
               hold[k] = int'($urandom_range(1, 14));
               if (k < N) begin
                  v = ($urandom_range(0, 2) == 0);
                  kv[k] = v;
               end else begin
                  key_restart = ($urandom_range(0, 7) == 0);
               end
            end else begin
               hold[k]--;
            end
         end
         key_level = kv;
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0; key_level = '0; key_restart = 1'b0;
      cyc(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
